// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package pipeline_pkg;

  // Stage indices of the tracked post-ID stages.
  localparam int unsigned EXE_IDX = 0;
  localparam int unsigned MEM_IDX = 1;
  localparam int unsigned WB_IDX  = 2;

  // Scoreboard destination field is wide enough for any supported REG_W (<= 8).
  localparam int unsigned SB_DEST_W = 8;

  typedef enum logic [2:0] {
    StRun,
    StLoadStall,
    StMemStall,
    StDrain,
    StHalted
  } hz_state_e;

  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 reg_write;
    logic                 is_load;
    logic                 mem_access;
    logic                 halt;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard with per-source lowest-index match.
import pipeline_pkg::*;

module hazard_scoreboard #(
  parameter int unsigned NUM_SRC        = 3,
  parameter int unsigned NUM_FWD_STAGES = 3,
  parameter int unsigned MEM_STAGE      = 1,
  parameter int unsigned REG_W          = 5,
  parameter int unsigned IDX_W          = (NUM_FWD_STAGES > 1) ? $clog2(NUM_FWD_STAGES) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_b,
  input  logic                             i_advance,
  input  logic                             i_issue,
  input  sb_entry_t                        i_id_entry,
  input  logic [NUM_SRC-1:0][REG_W-1:0]    i_src_num,
  output logic [NUM_SRC-1:0]               o_hit,
  output logic [NUM_SRC-1:0]               o_is_load,
  output logic [NUM_SRC-1:0][IDX_W-1:0]    o_match_idx,
  output logic                             o_mem_busy,
  output logic                             o_halt_inflight,
  output logic                             o_halt_last
);

  sb_entry_t r_sb [NUM_FWD_STAGES];

  // Shift entries toward WB on advancing cycles; entry 0 takes the issuing op or a bubble.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      for (int k = 0; k < NUM_FWD_STAGES; k++) begin
        r_sb[k] <= '0;
      end
    end else if (i_advance) begin
      r_sb[0] <= i_issue ? i_id_entry : '0;
      for (int k = 1; k < NUM_FWD_STAGES; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  // Per-source match; scanning high to low leaves the youngest (lowest index) producer.
  always_comb begin
    o_hit       = '0;
    o_is_load   = '0;
    o_match_idx = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
        if (r_sb[k].valid && r_sb[k].reg_write && (r_sb[k].dest != '0) &&
            (r_sb[k].dest == SB_DEST_W'(i_src_num[s]))) begin
          o_hit[s]       = 1'b1;
          o_is_load[s]   = r_sb[k].is_load;
          o_match_idx[s] = IDX_W'(k);
        end
      end
    end
  end

  // Summary flags used by the control FSM.
  always_comb begin
    o_halt_inflight = 1'b0;
    for (int k = 0; k < NUM_FWD_STAGES; k++) begin
      o_halt_inflight = o_halt_inflight | (r_sb[k].valid & r_sb[k].halt);
    end
    o_halt_last = r_sb[NUM_FWD_STAGES-1].valid & r_sb[NUM_FWD_STAGES-1].halt;
    o_mem_busy  = r_sb[MEM_STAGE].valid & r_sb[MEM_STAGE].mem_access;
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Forwarding select, load-use / miss stall, redirect flush and halt drain control.
import pipeline_pkg::*;

module pipeline_hazard_unit #(
  parameter int unsigned NUM_SRC          = 3,
  parameter int unsigned NUM_FWD_STAGES   = 3,
  parameter int unsigned LOAD_READY_STAGE = WB_IDX,
  parameter int unsigned MEM_STAGE        = MEM_IDX,
  parameter int unsigned REG_W            = 5,
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_b,
  input  logic                                  id_valid,
  input  logic [NUM_SRC-1:0][REG_W-1:0]         id_src_num,
  input  logic [NUM_SRC-1:0]                    id_src_used,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]        id_reg_data,
  input  logic [REG_W-1:0]                      id_dest_num,
  input  logic                                  id_reg_write,
  input  logic                                  id_is_load,
  input  logic                                  id_mem_access,
  input  logic                                  id_halt,
  input  logic                                  id_redirect,
  input  logic [NUM_FWD_STAGES-1:0][DATA_W-1:0] stage_data,
  input  logic                                  mem_hit,
  output logic [NUM_SRC-1:0][DATA_W-1:0]        src_data,
  output logic                                  freeze_if,
  output logic                                  freeze_id,
  output logic                                  bubble_ex,
  output logic                                  freeze_back,
  output logic                                  flush_if,
  output logic                                  halted,
  output logic [CNT_W-1:0]                      load_stall_cnt,
  output logic [CNT_W-1:0]                      mem_stall_cnt
);

  localparam int unsigned IDX_W = (NUM_FWD_STAGES > 1) ? $clog2(NUM_FWD_STAGES) : 1;

  hz_state_e                  r_state;
  hz_state_e                  w_state_next;
  logic [CNT_W-1:0]           r_load_stall_cnt;
  logic [CNT_W-1:0]           r_mem_stall_cnt;

  sb_entry_t                  w_id_entry;
  logic                       w_issue;
  logic [NUM_SRC-1:0]         w_hit;
  logic [NUM_SRC-1:0]         w_is_load;
  logic [NUM_SRC-1:0][IDX_W-1:0] w_match_idx;
  logic                       w_mem_busy;
  logic                       w_halt_inflight;
  logic                       w_halt_last;
  logic                       w_miss;
  logic                       w_hazard;
  logic                       w_load_inc;
  logic                       w_mem_inc;

  // Pack ID-stage fields into a scoreboard entry.
  always_comb begin
    w_id_entry            = '0;
    w_id_entry.valid      = 1'b1;
    w_id_entry.dest       = SB_DEST_W'(id_dest_num);
    w_id_entry.reg_write  = id_reg_write;
    w_id_entry.is_load    = id_is_load;
    w_id_entry.mem_access = id_mem_access;
    w_id_entry.halt       = id_halt;
  end

  hazard_scoreboard #(
    .NUM_SRC        (NUM_SRC),
    .NUM_FWD_STAGES (NUM_FWD_STAGES),
    .MEM_STAGE      (MEM_STAGE),
    .REG_W          (REG_W),
    .IDX_W          (IDX_W)
  ) u_scoreboard (
    .i_clk           (clk),
    .i_rst_b         (rst_b),
    .i_advance       (~freeze_back),
    .i_issue         (w_issue),
    .i_id_entry      (w_id_entry),
    .i_src_num       (id_src_num),
    .o_hit           (w_hit),
    .o_is_load       (w_is_load),
    .o_match_idx     (w_match_idx),
    .o_mem_busy      (w_mem_busy),
    .o_halt_inflight (w_halt_inflight),
    .o_halt_last     (w_halt_last)
  );

  // Operand select and load-use detection; a load only hurts a source that is really read.
  always_comb begin
    w_hazard = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (w_hit[s] && (id_src_num[s] != '0)) begin
        src_data[s] = stage_data[w_match_idx[s]];
      end else begin
        src_data[s] = id_reg_data[s];
      end
      if (w_hit[s] && w_is_load[s] && id_src_used[s] &&
          (32'(w_match_idx[s]) < LOAD_READY_STAGE)) begin
        w_hazard = 1'b1;
      end
    end
    w_hazard = w_hazard & id_valid;
  end

  assign w_miss = w_mem_busy & ~mem_hit;

  // Next-state and control decode; priority is halted > miss > drain > load-use > run.
  always_comb begin
    w_state_next = r_state;
    freeze_if    = 1'b0;
    freeze_id    = 1'b0;
    bubble_ex    = 1'b0;
    freeze_back  = 1'b0;
    flush_if     = 1'b0;
    w_issue      = 1'b0;
    w_load_inc   = 1'b0;
    w_mem_inc    = 1'b0;
    if (r_state == StHalted) begin
      w_state_next = StHalted;
      freeze_if    = 1'b1;
    end else if (w_miss) begin
      w_state_next = StMemStall;
      freeze_if    = 1'b1;
      freeze_id    = 1'b1;
      freeze_back  = 1'b1;
      w_mem_inc    = 1'b1;
    end else if (w_halt_inflight) begin
      // Halt is in flight: keep inserting bubbles until it falls off the last stage.
      w_state_next = w_halt_last ? StHalted : StDrain;
      freeze_if    = 1'b1;
      bubble_ex    = 1'b1;
    end else if (w_hazard) begin
      w_state_next = StLoadStall;
      freeze_if    = 1'b1;
      freeze_id    = 1'b1;
      bubble_ex    = 1'b1;
      w_load_inc   = 1'b1;
    end else begin
      w_issue      = id_valid;
      flush_if     = id_valid & id_redirect;
      w_state_next = (id_valid && id_halt) ? StDrain : StRun;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Saturating stall counters.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_load_stall_cnt <= '0;
      r_mem_stall_cnt  <= '0;
    end else begin
      if (w_load_inc && (r_load_stall_cnt != '1)) begin
        r_load_stall_cnt <= r_load_stall_cnt + 1'b1;
      end
      if (w_mem_inc && (r_mem_stall_cnt != '1)) begin
        r_mem_stall_cnt <= r_mem_stall_cnt + 1'b1;
      end
    end
  end

  assign halted         = (r_state == StHalted);
  assign load_stall_cnt = r_load_stall_cnt;
  assign mem_stall_cnt  = r_mem_stall_cnt;

endmodule
